// File: rtl/kmul_pkg.sv
// Shared widths, default multiplier latency and enums for the wide Karatsuba sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package kmul_pkg;

  localparam int XW              = 256;      // multiplier X / request operand width
  localparam int YW              = 128;      // multiplier Y width (half of B)
  localparam int PW              = XW + YW;  // multiplier product width
  localparam int RW              = 2 * XW;   // full 256x256 product width
  localparam int MUL_LATENCY_DEF = 7;

  typedef enum logic {
    ISSUE_LO = 1'b0,
    ISSUE_HI = 1'b1
  } issue_state_e;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  // A*B = A*B_lo + (A*B_hi << 128); at 512 bits the sum cannot overflow.
  function automatic logic [RW-1:0] recombine(input logic [PW-1:0] lo,
                                              input logic [PW-1:0] hi);
    return RW'(lo) + (RW'(hi) << YW);
  endfunction

endpackage

// File: rtl/kseq_rsp_fifo.sv
// Response FIFO, first-word fall-through: head_o/vld_o reflect the oldest entry.
// Latency: a push is visible at the head one cycle later; pop takes effect at the clock edge.
// Backpressure: none internally; the producer must never push when full (credit-guarded upstream).
module kseq_rsp_fifo
  import kmul_pkg::*;
#(
  parameter int W     = RW,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         vld_o,
  output logic [W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;
  logic          full;

  assign do_pop = pop_i && (cnt_q != '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign vld_o  = (cnt_q != '0);
  // Zero when empty so the response port reads 0 after reset, not stale storage.
  assign head_o = vld_o ? mem_q[rd_q] : '0;

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
    if (push_i) wr_d = wr_q + AW'(1);
    if (do_pop) rd_d = rd_q + AW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array, deliberately not reset; emptiness is tracked by cnt_q.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_q] <= push_dat_i;
  end

  // The credit scheme must make a push into a full FIFO impossible.
  always @(posedge clock) begin
    if (!reset && push_i) assert (!full);
  end

endmodule

// File: rtl/karatsuba_wide_sequencer.sv
// 256x256 multiply sequencer: splits each request into two 256x128 multiplier beats and recombines to 512 bits.
// Latency: request accept to rsp_valid = 2 + MUL_LATENCY + 1 cycles (10 by default); one request per 2 cycles peak.
// Backpressure: credits reserve a FIFO slot per accepted request, so the non-stallable multiplier never overruns it.
// Optional build macro KSEQ_LAT_CHECK_EN adds a sticky multiplier latency checker on lat_err.
module karatsuba_wide_sequencer
  import kmul_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int RSP_DEPTH   = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [XW-1:0] req_a,
  input  logic [XW-1:0] req_b,
  output logic          mul_in_valid,
  output logic [XW-1:0] mul_x,
  output logic [YW-1:0] mul_y,
  input  logic [PW-1:0] mul_p,
  input  logic          mul_out_valid,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_prod,
  output logic          lat_err
);

  localparam int DW = $clog2(MUL_LATENCY + 1);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  issue_state_e  state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [XW-1:0] a_q, a_d;
  logic [YW-1:0] bhi_q, bhi_d;
  logic          mul_in_valid_q, mul_in_valid_d;
  logic [XW-1:0] mul_x_q, mul_x_d;
  logic [YW-1:0] mul_y_q, mul_y_d;
  phase_e        phase_q, phase_d;
  logic [PW-1:0] lo_q, lo_d;

  logic          accept;
  logic          pop;
  logic          beat_vld;
  logic          push;
  logic [RW-1:0] push_dat;

  // Gated by reset so nothing is accepted on a cycle whose state is being discarded.
  assign req_ready = !reset && (state_q == ISSUE_LO) && (drain_q == '0) && (credits_q != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  // Multiplier valid stages are not reset, so pulses during the drain window are stale.
  assign beat_vld  = mul_out_valid && (drain_q == '0);

  assign mul_in_valid = mul_in_valid_q;
  assign mul_x        = mul_x_q;
  assign mul_y        = mul_y_q;

  // Issue FSM: low-half beat on accept, high-half beat on the following cycle.
  always_comb begin
    state_d        = state_q;
    mul_in_valid_d = 1'b0;
    mul_x_d        = mul_x_q;
    mul_y_d        = mul_y_q;
    a_d            = a_q;
    bhi_d          = bhi_q;
    case (state_q)
      ISSUE_LO: begin
        if (accept) begin
          mul_in_valid_d = 1'b1;
          mul_x_d        = req_a;
          mul_y_d        = req_b[YW-1:0];
          a_d            = req_a;
          bhi_d          = req_b[XW-1:YW];
          state_d        = ISSUE_HI;
        end
      end
      ISSUE_HI: begin
        mul_in_valid_d = 1'b1;
        mul_x_d        = a_q;
        mul_y_d        = bhi_q;
        state_d        = ISSUE_LO;
      end
      default: state_d = ISSUE_LO;
    endcase
  end

  // Collect: hold the low partial product, then push the recombined result on the high beat.
  always_comb begin
    phase_d  = phase_q;
    lo_d     = lo_q;
    push     = 1'b0;
    push_dat = '0;
    if (beat_vld) begin
      if (phase_q == PH_LO) begin
        lo_d    = mul_p;
        phase_d = PH_HI;
      end else begin
        push     = 1'b1;
        push_dat = recombine(lo_q, mul_p);
        phase_d  = PH_LO;
      end
    end
  end

  // Credits track unreserved FIFO slots; the drain counter runs down once after reset.
  always_comb begin
    credits_d = credits_q - CW'(accept) + CW'(pop);
    drain_d   = drain_q;
    if (drain_q != '0) drain_d = drain_q - DW'(1);
  end

  // Sequencer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ISSUE_LO;
      drain_q        <= DW'(MUL_LATENCY);
      credits_q      <= CW'(RSP_DEPTH);
      a_q            <= '0;
      bhi_q          <= '0;
      mul_in_valid_q <= 1'b0;
      mul_x_q        <= '0;
      mul_y_q        <= '0;
      phase_q        <= PH_LO;
      lo_q           <= '0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      credits_q      <= credits_d;
      a_q            <= a_d;
      bhi_q          <= bhi_d;
      mul_in_valid_q <= mul_in_valid_d;
      mul_x_q        <= mul_x_d;
      mul_y_q        <= mul_y_d;
      phase_q        <= phase_d;
      lo_q           <= lo_d;
    end
  end

  kseq_rsp_fifo #(
    .W     (RW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (rsp_ready),
    .vld_o      (rsp_valid),
    .head_o     (rsp_prod)
  );

`ifdef KSEQ_LAT_CHECK_EN
  logic [MUL_LATENCY-1:0] vpipe_q, vpipe_d;
  logic                   lat_err_q, lat_err_d;

  // Delay issued valids by MUL_LATENCY and flag any cycle the multiplier disagrees.
  always_comb begin
    vpipe_d   = (vpipe_q << 1) | MUL_LATENCY'(mul_in_valid_q);
    lat_err_d = lat_err_q;
    if ((drain_q == '0) && (vpipe_q[MUL_LATENCY-1] != mul_out_valid)) lat_err_d = 1'b1;
  end

  // Latency checker registers; the error is sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      vpipe_q   <= '0;
      lat_err_q <= 1'b0;
    end else begin
      vpipe_q   <= vpipe_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign lat_err = lat_err_q;
`else
  assign lat_err = 1'b0;
`endif

endmodule

// File: tb/tb_karatsuba_wide_sequencer.sv
// Bench for karatsuba_wide_sequencer: behavioural 7-cycle multiplier plus product scoreboard.
// Directed corner cases, backpressure, mid-operation reset and randomized traffic.
// Expected products come from plain 512-bit arithmetic on the request operands.
module tb_karatsuba_wide_sequencer;

  localparam int LAT = 7;

`ifdef KSEQ_LAT_CHECK_EN
  localparam logic LAT_EXP = 1'b1;
`else
  localparam logic LAT_EXP = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [255:0] req_a = '0;
  logic [255:0] req_b = '0;
  logic         mul_in_valid;
  logic [255:0] mul_x;
  logic [127:0] mul_y;
  logic [383:0] mul_p;
  logic         mul_out_valid;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [511:0] rsp_prod;
  logic         lat_err;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  karatsuba_wide_sequencer #(
    .MUL_LATENCY (LAT),
    .RSP_DEPTH   (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .mul_in_valid  (mul_in_valid),
    .mul_x         (mul_x),
    .mul_y         (mul_y),
    .mul_p         (mul_p),
    .mul_out_valid (mul_out_valid),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_prod      (rsp_prod),
    .lat_err       (lat_err)
  );

  // Behavioural multiplier: only the first stage honours reset; later stages keep shifting.
  logic         pv [LAT];
  logic [383:0] pp [LAT];
  logic         stale_v  = 1'b0;
  logic         dly_req  = 1'b0;
  logic         dly_done = 1'b0;
  logic         arm_q    = 1'b0;
  logic         late_v   = 1'b0;
  logic [383:0] late_p   = '0;

  always @(posedge clock) begin
    pv[0] <= reset ? 1'b0 : mul_in_valid;
    pp[0] <= {128'd0, mul_x} * {256'd0, mul_y};
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pp[i] <= pp[i-1];
    end
    late_v <= arm_q && pv[LAT-1];
    late_p <= pp[LAT-1];
    if (arm_q && pv[LAT-1]) dly_done <= 1'b1;
    arm_q <= dly_req && !dly_done;
  end

  assign mul_out_valid = (pv[LAT-1] && !arm_q) || late_v || stale_v;
  assign mul_p         = late_v ? late_p : pp[LAT-1];

  int           n_chk  = 0;
  int           n_pass = 0;
  int           acc_cyc = 0;
  logic [511:0] exp_q [$];
  bit           done_r = 1'b0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [511:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
    return {256'd0, a} * {256'd0, b};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard: every response handshake must match the oldest outstanding product.
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 512'(rsp_valid), 512'd0);
      else chk("rsp_prod", rsp_prod, exp_q.pop_front());
    end
  end

  task automatic send(input logic [255:0] a, input logic [255:0] b,
                      input logic [511:0] e, output int waited);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    waited    = 0;
    @(negedge clock);
    while (!req_ready && waited < 40) begin
      waited++;
      @(negedge clock);
    end
    chk("req_ready", 512'(req_ready), 512'd1);
    if (req_ready) begin
      exp_q.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 512'(exp_q.size()), 512'd0);
    @(posedge clock); #1;
  endtask

  task automatic apply_reset(input int n);
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Post-reset window: check reset outputs, inject stale multiplier pulses, time req_ready.
  task automatic post_reset(output int rdy_at, output int rv_cnt);
    rdy_at = -1;
    rv_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      stale_v = (i == 1) || (i == 3) || (i == 6);
      @(negedge clock);
      if (i == 0) begin
        chk("rst_req_ready", 512'(req_ready), 512'd0);
        chk("rst_mul_in_valid", 512'(mul_in_valid), 512'd0);
        chk("rst_mul_x", 512'(mul_x), 512'd0);
        chk("rst_mul_y", 512'(mul_y), 512'd0);
        chk("rst_rsp_valid", 512'(rsp_valid), 512'd0);
        chk("rst_rsp_prod", rsp_prod, 512'd0);
        chk("rst_lat_err", 512'(lat_err), 512'd0);
      end
      if (rsp_valid) rv_cnt++;
      if (rdy_at < 0 && req_ready) rdy_at = i;
      @(posedge clock); #1;
    end
    stale_v = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int w, rdy_at, rv_cnt, cnt;
    logic [255:0] a, b;
    logic [511:0] k_ones;
    logic [255:0] ca, cb;

    // Power-up reset and drain window.
    apply_reset(4);
    post_reset(rdy_at, rv_cnt);
    chk("drain_cycles", 512'(rdy_at), 512'd7);
    chk("drain_no_rsp", 512'(rv_cnt), 512'd0);

    // A=1, B=2^128: beat order and accept-to-response latency.
    rsp_ready = 1'b1;
    send(256'd1, 256'd1 << 128, 512'd1 << 128, w);
    req_valid = 1'b0;
    @(negedge clock);
    chk("beat_lo_vld", 512'(mul_in_valid), 512'd1);
    chk("beat_lo_y", 512'(mul_y), 512'd0);
    chk("beat_lo_x", 512'(mul_x), 512'd1);
    @(negedge clock);
    chk("beat_hi_vld", 512'(mul_in_valid), 512'd1);
    chk("beat_hi_y", 512'(mul_y), 512'd1);
    @(negedge clock);
    chk("beat_idle", 512'(mul_in_valid), 512'd0);
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    chk("accept_to_rsp", 512'(cyc - acc_cyc), 512'd10);
    @(posedge clock); #1;
    wait_empty("t1_drain");

    // All-ones operands and a fixed wide pair.
    k_ones = 512'd1 - (512'd1 << 257);
    send('1, '1, k_ones, w);
    ca = 256'h92e5_4c1f_7a03_b8d6_e1f2_0c9a_5b37_d4e8_6f01_a2c3_b4d5_e6f7_0819_2a3b_4c5d_13a2;
    cb = 256'he3b8_0f4e_9d2c_7b61_a5f3_c8e0_17d9_4b2a_6e85_f3c1_09b7_d2a4_5e6f_7081_92a3_799d;
    send(ca, cb, ref_mul(ca, cb), w);
    chk("tput_wait", 512'(w), 512'd1);
    req_valid = 1'b0;
    wait_empty("t2_drain");

    // Backpressure: four credits, then stall until a pop.
    rsp_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      a = rnd256();
      b = rnd256();
      send(a, b, ref_mul(a, b), w);
    end
    req_a = rnd256();
    req_b = rnd256();
    req_valid = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (req_ready) cnt++;
    end
    chk("stall_rdy", 512'(cnt), 512'd0);
    chk("stall_rsp_vld", 512'(rsp_valid), 512'd1);
    if (exp_q.size() != 0) chk("stall_head", rsp_prod, exp_q[0]);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    a = req_a;
    b = req_b;
    send(a, b, ref_mul(a, b), w);
    chk("pop_to_rdy", 512'(w), 512'd1);
    a = rnd256();
    b = rnd256();
    send(a, b, ref_mul(a, b), w);
    req_valid = 1'b0;
    wait_empty("t3_drain");

    // Randomized traffic with random response backpressure.
    done_r = 1'b0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          a = rnd256();
          b = rnd256();
          if (n == 3) a = '0;
          if (n == 5) b = '1;
          send(a, b, ref_mul(a, b), w);
          if ($urandom_range(0, 2) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
              @(posedge clock); #1;
            end
          end
        end
        req_valid = 1'b0;
        done_r = 1'b1;
      end
      begin
        while (!done_r) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          @(posedge clock); #1;
        end
        rsp_ready = 1'b1;
      end
    join
    wait_empty("rand_drain");

    // Reset during the high beat of request 3; stale pulses during the drain window.
    for (int n = 0; n < 3; n++) begin
      a = rnd256();
      b = rnd256();
      send(a, b, ref_mul(a, b), w);
    end
    apply_reset(1);
    post_reset(rdy_at, rv_cnt);
    chk("midrst_drain", 512'(rdy_at), 512'd7);
    chk("midrst_no_rsp", 512'(rv_cnt), 512'd0);
    a = rnd256();
    b = rnd256();
    send(a, b, ref_mul(a, b), w);
    req_valid = 1'b0;
    wait_empty("midrst_recover");

    // One high beat delivered a cycle late.
    a = rnd256();
    b = rnd256();
    send(a, b, ref_mul(a, b), w);
    req_valid = 1'b0;
    cnt = 0;
    @(negedge clock);
    while (!mul_out_valid && cnt < 30) begin
      @(negedge clock);
      cnt++;
    end
    chk("lo_beat_seen", 512'(mul_out_valid), 512'd1);
    dly_req = 1'b1;
    repeat (15) @(negedge clock);
    chk("lat_err_set", 512'(lat_err), 512'(LAT_EXP));
    @(posedge clock); #1;
    wait_empty("lat_drain");
    repeat (10) @(negedge clock);
    chk("lat_err_sticky", 512'(lat_err), 512'(LAT_EXP));
    @(posedge clock); #1;
    apply_reset(2);
    post_reset(rdy_at, rv_cnt);
    chk("final_drain", 512'(rdy_at), 512'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/karatsuba_wide_sequencer.md
Name: karatsuba_wide_sequencer

Overview:
- Front-end/back-end sequencer wrapped around the 256x128 constant-latency Karatsuba multiplier (7-cycle, valid-only, no backpressure).
- Accepts full 256x256 multiply requests on a ready/valid interface and issues each as two multiplier beats: low Y half, then high Y half.
- Recombines the two 384-bit partial products into a 512-bit product and presents it on a ready/valid response port.
- Uses credit-based issue so the non-stallable multiplier never overruns the response buffer.

Parameters:
- MUL_LATENCY, 7, cycles from mul_in_valid to the matching mul_out_valid.
- RSP_DEPTH, 4, response FIFO entries (power of two, >=2).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_a  in  256  multiplicand A
- req_b  in  256  multiplier B
- mul_in_valid  out  1  drives multiplier in_valid
- mul_x  out  256  drives multiplier X
- mul_y  out  128  drives multiplier Y
- mul_p  in  384  multiplier product P
- mul_out_valid  in  1  multiplier out_valid
- rsp_valid  out  1  response valid (FIFO non-empty)
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_prod  out  512  A*B, FIFO head
- lat_err  out  1  sticky latency-check error (see Optional Feature)

Behaviour:
- Reset values: req_ready=0, mul_in_valid=0, mul_x=0, mul_y=0, rsp_valid=0, rsp_prod=0, lat_err=0. FSM=ISSUE_LO, credits=RSP_DEPTH, FIFO empty, collect phase=LO, drain counter=MUL_LATENCY.
- Drain window: for MUL_LATENCY cycles after reset deasserts, req_ready=0 and mul_out_valid is ignored. The multiplier's internal valid stages S2..S6 are not reset, so stale pulses can appear in this window.
- Issue FSM:
  - ISSUE_LO: req_ready = (drain==0) && (credits>0). On accept: mul_in_valid=1, mul_x=req_a, mul_y=req_b[127:0]; capture a_reg=req_a, bhi_reg=req_b[255:128]; credits-1; go to ISSUE_HI.
  - ISSUE_HI: req_ready=0; mul_in_valid=1, mul_x=a_reg, mul_y=bhi_reg; go to ISSUE_LO.
  - Otherwise mul_in_valid=0. mul_x/mul_y hold their last value.
  - Peak throughput: one request per 2 cycles. mul_x/mul_y/mul_in_valid are registered outputs.
- Collect:
  - mul_out_valid with phase=LO: lo_reg=mul_p, phase goes to HI.
  - mul_out_valid with phase=HI: push lo_reg + (mul_p<<128) to the FIFO, computed at 512-bit width; the result cannot overflow. Phase goes to LO.
  - Beats always arrive in issue order and in pairs.
- Credits:
  - Count free FIFO slots not yet reserved; range 0..RSP_DEPTH.
  - Accept decrements, response pop increments; simultaneous accept and pop leaves credits unchanged.
  - Push never occurs when the FIFO is full; any such push is a design bug, asserted in simulation.
- Response: FIFO with first-word fall-through; rsp_prod is stable while rsp_valid && !rsp_ready. Request-accept to rsp_valid = 2 + MUL_LATENCY + 1 cycles = 10 at default.
- Reset mid-operation: all in-flight work is discarded, including an ISSUE_HI in progress, partial lo_reg and FIFO contents. Returns to reset state the next cycle; the drain window restarts.

Optional Feature:
- Macro: KSEQ_LAT_CHECK_EN.
- With the macro: a MUL_LATENCY-deep shift register of mul_in_valid is compared each cycle (outside the drain window) against mul_out_valid. Any mismatch sets lat_err=1, sticky until reset.
- Without the macro: the shift register is not built and lat_err is tied to 0.

Decomposition:
- Shared package kmul_pkg: XW=256, YW=128, PW=384, RW=512, default MUL_LATENCY=7, FSM state enum {ISSUE_LO, ISSUE_HI}.
- One sub-module: kseq_rsp_fifo (parameterised width RW, depth RSP_DEPTH, FWFT).

Test Plan:
- A=1, B=2^128, rsp_ready=1 -> mul_y beats 0 then 1. rsp_prod=2^128 exactly 10 cycles after accept.
- A=B=2^256-1 -> rsp_prod=2^512-2^257+1. A=0x92e5...13a2, B=0xe3b8...799d -> matches the 512-bit reference product.
- rsp_ready=0, req_valid held high with 6 distinct requests -> 4 accepted, then req_ready=0. Raising rsp_ready returns all results in order; a pop restores req_ready within 1 cycle.
- Reset asserted on the ISSUE_HI cycle of request 3, with stale multiplier valids injected during the drain window -> no rsp_valid is ever produced for the discarded work, and req_ready stays 0 for 7 cycles after reset.
- With KSEQ_LAT_CHECK_EN, a behavioural multiplier model delays one mul_out_valid by 1 cycle -> lat_err=1 and stays 1 until reset. Without the macro, lat_err stays 0.
